// File: rtl/axi_w_responder.sv
// AXI4 write-channel responder: one AW, INCR burst of W beats into a word-wide
// SRAM port, then a single B response. Optional W_RESP_CHECK_EN enables burst length checking.
module axi_w_responder #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [3:0]        awlen,
  input  logic              awvalid,
  output logic              awready,
  input  logic [36:0]       wpack,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_din
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ID_W-1:0]     id_lat_r;
  logic [ID_W-1:0]     bid_r;
  logic [1:0]          bresp_r;
  logic [MEM_AW-1:0]   ptr_r;
  logic [3:0]          len_r;
  logic [4:0]          cnt_r;
  logic                err_r;
  logic                aw_hs_s;
  logic                w_hs_s;
  logic                w_last_s;
  logic                beat_err_s;
  logic                beat_drop_s;
  logic                unused_addr_s;

  assign w_last_s      = wpack[0];
  assign bid           = bid_r;
  assign bresp         = bresp_r;
  assign unused_addr_s = ^{awaddr[ADDR_W-1:MEM_AW+2], awaddr[1:0]};

`ifdef W_RESP_CHECK_EN
  // Per-beat length check against the latched awlen; beats past awlen are dropped
  always_comb begin
    beat_err_s  = 1'b0;
    beat_drop_s = 1'b0;
    if (cnt_r > {1'b0, len_r}) begin
      beat_drop_s = 1'b1;
    end else begin
      beat_drop_s = 1'b0;
    end
    if ((w_last_s && (cnt_r < {1'b0, len_r})) ||
        (!w_last_s && (cnt_r == {1'b0, len_r}))) begin
      beat_err_s = 1'b1;
    end else begin
      beat_err_s = 1'b0;
    end
  end
`else
  logic unused_cfg_s;
  assign beat_err_s   = 1'b0;
  assign beat_drop_s  = 1'b0;
  assign unused_cfg_s = ^{len_r, cnt_r};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, handshakes and the combinational memory write port
  always_comb begin
    state_nxt_s = state_r;
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    mem_we      = 4'b0000;
    mem_addr    = ptr_r;
    mem_din     = wpack[36:5];
    aw_hs_s     = 1'b0;
    w_hs_s      = 1'b0;
    if (rst) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          awready = 1'b1;
          if (awvalid) begin
            aw_hs_s     = 1'b1;
            state_nxt_s = DATA;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        DATA: begin
          wready = 1'b1;
          if (wvalid) begin
            w_hs_s = 1'b1;
            mem_we = beat_drop_s ? 4'b0000 : wpack[4:1];
            if (w_last_s) begin
              state_nxt_s = RESP;
            end else begin
              state_nxt_s = DATA;
            end
          end else begin
            state_nxt_s = DATA;
          end
        end
        RESP: begin
          bvalid = 1'b1;
          if (bready) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = RESP;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // Burst context: pointer, beat count, error flag; B fields load only on entry to RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      id_lat_r <= {ID_W{1'b0}};
      bid_r    <= {ID_W{1'b0}};
      bresp_r  <= RESP_OKAY;
      ptr_r    <= {MEM_AW{1'b0}};
      len_r    <= 4'd0;
      cnt_r    <= 5'd0;
      err_r    <= 1'b0;
    end else if (aw_hs_s) begin
      id_lat_r <= awid;
      ptr_r    <= awaddr[MEM_AW+1:2];
      len_r    <= awlen;
      cnt_r    <= 5'd0;
      err_r    <= 1'b0;
    end else if (w_hs_s) begin
      ptr_r <= ptr_r + MEM_AW'(1);
      cnt_r <= (cnt_r == 5'd16) ? cnt_r : cnt_r + 5'd1;
      err_r <= err_r | beat_err_s;
      if (w_last_s) begin
        bid_r   <= id_lat_r;
        bresp_r <= (err_r | beat_err_s) ? RESP_SLVERR : RESP_OKAY;
      end else begin
        bid_r   <= bid_r;
        bresp_r <= bresp_r;
      end
    end else begin
      ptr_r <= ptr_r;
      cnt_r <= cnt_r;
      err_r <= err_r;
    end
  end

endmodule

// File: tb/tb_axi_w_responder.sv
// Directed self-checking bench for axi_w_responder; expectations follow W_RESP_CHECK_EN.
module tb_axi_w_responder;
  logic        clk;
  logic        rst;
  logic [7:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [36:0] wpack;
  logic        wvalid;
  logic        wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_din;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef W_RESP_CHECK_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
  localparam logic [3:0] DROP_WE  = 4'b0000;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
  localparam logic [3:0] DROP_WE  = 4'b1111;
`endif

  axi_w_responder #(.ID_W(8), .ADDR_W(32), .MEM_AW(14)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wpack(wpack), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    #1;
    chk("aw_awready", 64'(awready), 64'd1);
    tick();
    awvalid = 1'b0;
    #1;
    chk("aw_then_awready_low", 64'(awready), 64'd0);
    chk("aw_then_wready", 64'(wready), 64'd1);
  endtask

  task automatic beat(input logic [31:0] data, input logic [3:0] strb, input logic last,
                      input logic [3:0] exp_we, input logic [13:0] exp_addr);
    wpack = {data, strb, last}; wvalid = 1'b1;
    #1;
    chk("beat_mem_we", 64'(mem_we), 64'(exp_we));
    chk("beat_mem_addr", 64'(mem_addr), 64'(exp_addr));
    chk("beat_mem_din", 64'(mem_din), 64'(data));
    tick();
    wvalid = 1'b0;
  endtask

  task automatic expect_resp(input logic [7:0] id, input logic [1:0] resp);
    #1;
    chk("resp_bvalid", 64'(bvalid), 64'd1);
    chk("resp_bid", 64'(bid), 64'(id));
    chk("resp_bresp", 64'(bresp), 64'(resp));
    chk("resp_wready", 64'(wready), 64'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    #1;
    chk("post_b_awready", 64'(awready), 64'd1);
    chk("post_b_bvalid", 64'(bvalid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; awid = 8'h00; awaddr = 32'h0; awlen = 4'd0; awvalid = 1'b0;
    wpack = 37'h0; wvalid = 1'b0; bready = 1'b0;
    tick();
    tick();
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_awready", 64'(awready), 64'd1);
    chk("idle_bvalid", 64'(bvalid), 64'd0);
    chk("idle_mem_we", 64'(mem_we), 64'd0);
    chk("idle_bid", 64'(bid), 64'd0);
    chk("idle_bresp", 64'(bresp), 64'd0);

    // 4-beat burst at byte 0x100 -> words 0x40..0x43
    send_aw(8'h5A, 32'h0000_0100, 4'd3);
    beat(32'h0000_0011, 4'hF, 1'b0, 4'hF, 14'h040);
    beat(32'h0000_0022, 4'hF, 1'b0, 4'hF, 14'h041);
    beat(32'h0000_0033, 4'hF, 1'b0, 4'hF, 14'h042);
    beat(32'h0000_0044, 4'hF, 1'b1, 4'hF, 14'h043);
    expect_resp(8'h5A, 2'b00);

    // single beat, partial strobe, bready held low 3 cycles
    send_aw(8'h33, 32'h0000_0008, 4'd0);
    beat(32'hDEAD_BEEF, 4'b0101, 1'b1, 4'b0101, 14'h002);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_bvalid", 64'(bvalid), 64'd1);
      chk("hold_bid", 64'(bid), 64'h33);
      chk("hold_bresp", 64'(bresp), 64'd0);
      chk("hold_awready", 64'(awready), 64'd0);
      tick();
    end
    expect_resp(8'h33, 2'b00);

    // pointer wrap from last word to 0
    send_aw(8'h21, 32'h0000_FFFC, 4'd1);
    beat(32'hA5A5_0001, 4'hF, 1'b0, 4'hF, 14'h3FFF);
    beat(32'hA5A5_0002, 4'hF, 1'b1, 4'hF, 14'h0000);
    expect_resp(8'h21, 2'b00);

    // early WLAST
    send_aw(8'h61, 32'h0000_0200, 4'd3);
    beat(32'h0000_0101, 4'hF, 1'b0, 4'hF, 14'h080);
    beat(32'h0000_0102, 4'hF, 1'b1, 4'hF, 14'h081);
    expect_resp(8'h61, ERR_RESP);

    // late WLAST: beats past awlen are dropped when checking
    send_aw(8'h62, 32'h0000_0300, 4'd1);
    beat(32'h0000_0201, 4'hF, 1'b0, 4'hF, 14'h0C0);
    beat(32'h0000_0202, 4'hF, 1'b0, 4'hF, 14'h0C1);
    beat(32'h0000_0203, 4'hF, 1'b0, DROP_WE, 14'h0C2);
    beat(32'h0000_0204, 4'hF, 1'b1, DROP_WE, 14'h0C3);
    expect_resp(8'h62, ERR_RESP);

    // reset mid-burst after the first beat
    send_aw(8'h77, 32'h0000_0400, 4'd3);
    beat(32'h0000_0301, 4'hF, 1'b0, 4'hF, 14'h100);
    rst = 1'b1;
    wpack = {32'h0000_0302, 4'hF, 1'b0}; wvalid = 1'b1;
    #1;
    chk("rstmid_mem_we", 64'(mem_we), 64'd0);
    chk("rstmid_wready", 64'(wready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("after_rst_awready", 64'(awready), 64'd1);
    chk("after_rst_bid", 64'(bid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("after_rst_wready", 64'(wready), 64'd0);
      chk("after_rst_mem_we", 64'(mem_we), 64'd0);
      chk("after_rst_bvalid", 64'(bvalid), 64'd0);
      tick();
      #1;
    end
    wvalid = 1'b0;

    // clean burst after errors: flag must be cleared
    send_aw(8'h44, 32'h0000_0000, 4'd0);
    beat(32'h1234_5678, 4'b1000, 1'b1, 4'b1000, 14'h000);
    expect_resp(8'h44, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_w_responder.md
# axi_w_responder

Single-clock AXI4 write-channel responder on the slave side of the bus: accepts one AW request, consumes the packed W beats produced by the master-side write path, drives word writes into an SRAM-style memory port, and returns a B response. It sits between the AXI fabric and a slave memory and handles INCR bursts of up to 16 32-bit words. One burst is in flight at a time.

## Interface

Parameters:
- ID_W, 8, width of AWID/BID
- ADDR_W, 32, AXI byte address width
- MEM_AW, 14, memory word-address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- awid  in  ID_W  write request ID
- awaddr  in  ADDR_W  start byte address; bits [1:0] ignored
- awlen  in  4  beats minus 1 (0..15)
- awvalid  in  1  AW valid
- awready  out  1  AW ready
- wpack  in  37  packed beat: [0] WLAST, [4:1] WSTRB, [36:5] WDATA
- wvalid  in  1  W valid
- wready  out  1  W ready
- bid  out  ID_W  response ID (latched AWID)
- bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- bvalid  out  1  B valid
- bready  in  1  B ready
- mem_we  out  4  per-byte write enable, active high
- mem_addr  out  MEM_AW  word address
- mem_din  out  32  write data

## Operation

- FSM states: IDLE, DATA, RESP.
- IDLE: awready=1. On awvalid&awready, latch awid, awaddr[MEM_AW+1:2] as the word pointer, and awlen; clear the beat counter and error flag; go to DATA.
- DATA: wready=1. A beat is accepted on wvalid&wready. mem_we=WSTRB, mem_addr=word pointer, mem_din=WDATA, all combinational in the accept cycle. Otherwise mem_we=0.
- After each beat, the word pointer increments modulo 2^MEM_AW (wraps to 0) and the beat counter increments.
- An accepted beat with WLAST=1 moves the FSM to RESP.
- RESP: bvalid=1 with bid and bresp held stable until bready. On bvalid&bready, go to IDLE.
- awready=0 outside IDLE. wready=0 outside DATA. bvalid=0 outside RESP.
- AW is not accepted while a burst or response is pending. There is no overlap between bursts.
- The length check (see Configuration) sets the error flag. bresp is SLVERR when the flag is set, otherwise OKAY.

## Timing

- Reset: state=IDLE, bvalid=0, bresp=0, bid=0, mem_we=0, wready=0. awready=0 while rst=1 and 1 in the first cycle after rst falls.
- AW handshake at edge n: wready=1 from cycle n+1. The earliest first beat is accepted at edge n+1.
- One beat per cycle at full throughput. The memory write takes effect at the accepting edge.
- WLAST beat accepted at edge m: bvalid=1 in cycle m+1.
- B handshake at edge k: awready=1 in cycle k+1. Minimum turnaround AW-to-AW is 3 cycles for a 1-beat burst.
- bid and bresp change only on entry to RESP.
- rst in any state returns to IDLE at the next edge. The pending burst is dropped with no B response, and no memory write occurs in the reset cycle.
- wvalid in IDLE or RESP is ignored. It is not consumed and no write occurs.

## Configuration

- W_RESP_CHECK_EN defined:
  - WLAST on beat index < awlen, or a beat index reaching awlen with WLAST=0, sets the error flag.
  - Beats past index awlen are still accepted until WLAST, but mem_we is forced to 0 for them.
  - bresp=SLVERR when the error flag is set.
- W_RESP_CHECK_EN undefined:
  - awlen is latched but unused.
  - The burst ends solely on WLAST and every accepted beat writes.
  - bresp is always OKAY.

## Test plan

- Reset, then idle: awready=1, bvalid=0, mem_we=0 in the first cycle after rst deasserts.
- AW id=0x5A, addr=0x100, len=3; 4 beats data 0x11..0x44, strb=4'hF, WLAST on the 4th:
  - mem_addr 0x40..0x43 with mem_we=4'hF.
  - bvalid one cycle after the last beat, bid=0x5A, bresp=OKAY.
- Single beat with strb=4'b0101 at addr=0x8: mem_we=4'b0101, mem_addr=2. Hold bready=0 for 3 cycles: bvalid, bid and bresp stay stable and awready stays 0.
- Burst len=1 starting at word 2^MEM_AW-1: second beat writes mem_addr=0 (wrap).
- With W_RESP_CHECK_EN: len=3 with WLAST on beat 1 gives bresp=SLVERR. len=1 with WLAST on beat 3 gives SLVERR, and beats 2 and 3 have mem_we=0. Without the macro, both cases give OKAY and all beats write.
- Assert rst mid-burst after beat 1 of len=3: next cycle state is IDLE, bvalid never asserts, and further wvalid beats are not accepted and do not write.
